cpu_regseq: RTL and testbench

- Register-access sequencer for the Intel8008 CPU core. It is the initiator side of the cpu_regbank interface.
- It accepts one decoded register operation at a time: MOV r1,r2 (Lr1r2), MVI r,imm (LrI), INR r, or DCR r.
- It turns each operation into the multi-cycle RD/WR/INC/DCR strobe sequence that the register bank expects.
- It computes the S/Z/P flags for INR/DCR by reading the result back.
- It sits between the instruction decoder and cpu_regbank. Its outputs connect directly to the regbank RD_I/WR_I/INC_I/DCR_I/ADDR_I/DAT_I, and its RB_DAT_I input connects to the regbank DAT_O.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/cpu_flaggen.sv | 13 +
 rtl/cpu_regbank.sv | 23 ++
 rtl/cpu_regseq.sv | 83 ++++++++
 tb/tb_cpu_regseq.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, sequencer state and flag definitions for the 8008 core blocks
package cpu_pkg;
  typedef enum logic [1:0] {OP_MOV = 2'b00, OP_MVI = 2'b01, OP_INR = 2'b10, OP_DCR = 2'b11} op_t;
  typedef enum logic [2:0] {S_IDLE, S_RDSRC, S_WRDST, S_STEP, S_RDBK, S_FIN} state_t;
  localparam logic [2:0] M_ADDR = 3'd7;
  localparam int FLG_S = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_P = 0;
endpackage

// File: rtl/cpu_flaggen.sv
// cpu_flaggen: combinational {S,Z,P} flags of a data value; P=1 means even parity
module cpu_flaggen
  import cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_val,
  output logic [2:0]    o_flag
);
  assign o_flag[FLG_S] = i_val[DW-1];
  assign o_flag[FLG_Z] = i_val == '0;
  assign o_flag[FLG_P] = ~^i_val;
endmodule

// File: rtl/cpu_regbank.sv
// cpu_regbank: register file with write, increment and decrement; read data is gated by RD_I
module cpu_regbank #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          CLK2_I,
  input  logic          nRST_I,
  input  logic          RD_I,
  input  logic          WR_I,
  input  logic          INC_I,
  input  logic          DCR_I,
  input  logic [AW-1:0] ADDR_I,
  input  logic [DW-1:0] DAT_I,
  output logic [DW-1:0] DAT_O
);
  logic [DW-1:0] r_regs [2**AW];
  always_ff @(posedge CLK2_I or negedge nRST_I)
    if (!nRST_I) for (int i = 0; i < 2**AW; i++) r_regs[i] <= '0;
    else if (WR_I)  r_regs[ADDR_I] <= DAT_I;
    else if (INC_I) r_regs[ADDR_I] <= r_regs[ADDR_I] + DW'(1);
    else if (DCR_I) r_regs[ADDR_I] <= r_regs[ADDR_I] - DW'(1);
  assign DAT_O = RD_I ? r_regs[ADDR_I] : '0;
endmodule

// File: rtl/cpu_regseq.sv
// cpu_regseq: turns one MOV/MVI/INR/DCR request into the regbank strobe sequence and updates S/Z/P
module cpu_regseq
  import cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          CLK2_I,
  input  logic          nRST_I,
  input  logic          STB_I,
  input  logic [1:0]    OP_I,
  input  logic [AW-1:0] DST_I,
  input  logic [AW-1:0] SRC_I,
  input  logic [DW-1:0] IMM_I,
  output logic          BUSY_O,
  output logic          DONE_O,
  output logic          ERR_O,
  output logic [2:0]    FLAG_O,
  output logic          RB_RD_O,
  output logic          RB_WR_O,
  output logic          RB_INC_O,
  output logic          RB_DCR_O,
  output logic [AW-1:0] RB_ADDR_O,
  output logic [DW-1:0] RB_DAT_O,
  input  logic [DW-1:0] RB_DAT_I
);
  state_t        r_state;
  op_t           r_op;
  logic [AW-1:0] r_dst, r_src;
  logic [DW-1:0] r_imm, r_tmp;
  logic          r_err;
  logic [2:0]    r_flag;
  logic [2:0]    w_flag;
  logic          w_merr, w_step;
  cpu_flaggen #(.DW(DW)) u_flaggen (.i_val(RB_DAT_I), .o_flag(w_flag));
  // The M pseudo-register lives in memory, so any op naming it is rejected up front
  assign w_merr = DST_I == M_ADDR || (OP_I == OP_MOV && SRC_I == M_ADDR);
  always_ff @(posedge CLK2_I or negedge nRST_I)
    if (!nRST_I) begin
      r_state <= S_IDLE;
      r_op    <= OP_MOV;
      r_dst   <= '0;
      r_src   <= '0;
      r_imm   <= '0;
      r_tmp   <= '0;
      r_err   <= 1'b0;
      r_flag  <= '0;
    end else case (r_state)
      S_IDLE: if (STB_I) begin
        r_op    <= op_t'(OP_I);
        r_dst   <= DST_I;
        r_src   <= SRC_I;
        r_imm   <= IMM_I;
        r_err   <= w_merr;
        r_state <= w_merr ? S_FIN : OP_I == OP_MOV ? S_RDSRC : OP_I == OP_MVI ? S_WRDST : S_STEP;
      end
      S_RDSRC: begin
        r_tmp   <= RB_DAT_I;
        r_state <= S_WRDST;
      end
      S_WRDST: r_state <= S_FIN;
      S_STEP:  r_state <= S_RDBK;
      S_RDBK: begin
        r_flag  <= w_flag;
        r_state <= S_FIN;
      end
      default: begin
        r_err   <= 1'b0;
        r_state <= S_IDLE;
      end
    endcase
  assign w_step    = r_state == S_STEP;
  assign RB_RD_O   = r_state == S_RDSRC || r_state == S_RDBK;
  assign RB_WR_O   = r_state == S_WRDST;
  assign RB_INC_O  = w_step && r_op == OP_INR;
  assign RB_DCR_O  = w_step && r_op == OP_DCR;
  assign RB_ADDR_O = r_state == S_RDSRC ? r_src : (RB_RD_O || RB_WR_O || w_step) ? r_dst : '0;
  assign RB_DAT_O  = RB_WR_O ? (r_op == OP_MOV ? r_tmp : r_imm) : '0;
  assign BUSY_O    = r_state != S_IDLE;
  assign DONE_O    = r_state == S_FIN;
  assign ERR_O     = DONE_O && r_err;
  assign FLAG_O    = r_flag;
endmodule

// File: tb/tb_cpu_regseq.sv
// tb_cpu_regseq: cpu_regseq driving a cpu_regbank, checked against a register-array reference model
module tb_cpu_regseq;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       stb = 1'b0;
  logic [1:0] op = '0;
  logic [2:0] dst = '0, src = '0;
  logic [7:0] imm = '0;
  logic       busy, done, err;
  logic [2:0] flag;
  logic       rd, wr, inc, dcr;
  logic [2:0] addr;
  logic [7:0] wdat, rdat;
  int checks = 0;
  int failures = 0;
  logic [7:0] m_bank [8];
  logic [2:0] m_flag;

  always #5 clk = ~clk;

  cpu_regseq u_dut (
    .CLK2_I(clk), .nRST_I(nrst), .STB_I(stb), .OP_I(op), .DST_I(dst), .SRC_I(src), .IMM_I(imm),
    .BUSY_O(busy), .DONE_O(done), .ERR_O(err), .FLAG_O(flag),
    .RB_RD_O(rd), .RB_WR_O(wr), .RB_INC_O(inc), .RB_DCR_O(dcr),
    .RB_ADDR_O(addr), .RB_DAT_O(wdat), .RB_DAT_I(rdat)
  );
  cpu_regbank u_rb (
    .CLK2_I(clk), .nRST_I(nrst), .RD_I(rd), .WR_I(wr), .INC_I(inc), .DCR_I(dcr),
    .ADDR_I(addr), .DAT_I(wdat), .DAT_O(rdat)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] szp(input logic [7:0] v);
    return {v[7], v == 8'h00, $countones(v) % 2 == 0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
    m_flag = 3'b000;
  endtask

  task automatic chk_bus(input string tag, input int e_rd, e_wr, e_inc, e_dcr, e_addr, e_dat);
    chk({tag, ".rd"}, int'(rd), e_rd);
    chk({tag, ".wr"}, int'(wr), e_wr);
    chk({tag, ".inc"}, int'(inc), e_inc);
    chk({tag, ".dcr"}, int'(dcr), e_dcr);
    chk({tag, ".addr"}, int'(addr), e_addr);
    chk({tag, ".dat"}, int'(wdat), e_dat);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle again
  task automatic run_op(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s, input logic [7:0] im);
    logic e;
    int   lat;
    logic [7:0] sv;
    e   = d == 3'd7 || (o == 2'b00 && s == 3'd7);
    lat = e ? 1 : o == 2'b01 ? 2 : 3;
    sv  = m_bank[s];
    stb = 1'b1; op = o; dst = d; src = s; imm = im;
    @(negedge clk);
    stb = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      chk("busy", int'(busy), 1);
      chk("done", int'(done), int'(k == lat));
      if (k == lat || e) chk_bus("idlebus", 0, 0, 0, 0, 0, 0);
      else if (o == 2'b00) begin
        if (k == 1) chk_bus("mov1", 1, 0, 0, 0, s, 0);
        else chk_bus("mov2", 0, 1, 0, 0, d, sv);
      end else if (o == 2'b01) chk_bus("mvi1", 0, 1, 0, 0, d, im);
      else if (k == 1) chk_bus("step", 0, 0, int'(o == 2'b10), int'(o == 2'b11), d, 0);
      else chk_bus("rdbk", 1, 0, 0, 0, d, 0);
    end
    chk("err", int'(err), int'(e));
    if (!e) begin
      case (o)
        2'b00: m_bank[d] = sv;
        2'b01: m_bank[d] = im;
        2'b10: m_bank[d] = m_bank[d] + 8'd1;
        default: m_bank[d] = m_bank[d] - 8'd1;
      endcase
      if (o[1]) m_flag = szp(m_bank[d]);
    end
    @(negedge clk);
    chk("busy_after", int'(busy), 0);
    chk("done_after", int'(done), 0);
    chk("flag", int'(flag), int'(m_flag));
    for (int i = 0; i < 7; i++) chk("bank", int'(u_rb.r_regs[i]), int'(m_bank[i]));
  endtask

  typedef struct {
    logic [1:0] o;
    logic [2:0] d, s;
    logic [7:0] im;
    logic [2:0] reg_i;
    logic [7:0] reg_v;
    logic [2:0] flg;
  } vec_t;

  initial begin
    vec_t tbl [9];
    tbl[0] = '{2'b01, 3'd2, 3'd0, 8'h5A, 3'd2, 8'h5A, 3'b000};
    tbl[1] = '{2'b00, 3'd4, 3'd2, 8'h00, 3'd4, 8'h5A, 3'b000};
    tbl[2] = '{2'b01, 3'd1, 3'd0, 8'hFF, 3'd1, 8'hFF, 3'b000};
    tbl[3] = '{2'b10, 3'd1, 3'd0, 8'h00, 3'd1, 8'h00, 3'b011};
    tbl[4] = '{2'b11, 3'd1, 3'd0, 8'h00, 3'd1, 8'hFF, 3'b101};
    tbl[5] = '{2'b01, 3'd7, 3'd0, 8'h12, 3'd0, 8'h00, 3'b101};
    tbl[6] = '{2'b00, 3'd0, 3'd7, 8'h00, 3'd0, 8'h00, 3'b101};
    tbl[7] = '{2'b00, 3'd4, 3'd4, 8'h00, 3'd4, 8'h5A, 3'b101};
    tbl[8] = '{2'b10, 3'd3, 3'd0, 8'h00, 3'd3, 8'h01, 3'b000};
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flag", int'(flag), 0);
    chk_bus("rst", 0, 0, 0, 0, 0, 0);
    nrst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].o, tbl[i].d, tbl[i].s, tbl[i].im);
      chk("tbl_reg", int'(u_rb.r_regs[tbl[i].reg_i]), int'(tbl[i].reg_v));
      chk("tbl_flag", int'(flag), int'(tbl[i].flg));
    end
    // STB held high across two MVIs: the second is taken only after FIN
    stb = 1'b1; op = 2'b01; dst = 3'd5; src = 3'd0; imm = 8'h11;
    @(negedge clk);
    dst = 3'd6; imm = 8'h22;
    chk_bus("b2b_first", 0, 1, 0, 0, 5, 8'h11);
    @(negedge clk);
    chk("b2b_fin", int'(done), 1);
    @(negedge clk);
    chk("b2b_idle", int'(busy), 0);
    chk("b2b_r6_untouched", int'(u_rb.r_regs[6]), int'(m_bank[6]));
    @(negedge clk);
    chk_bus("b2b_second", 0, 1, 0, 0, 6, 8'h22);
    @(negedge clk);
    stb = 1'b0;
    chk("b2b_fin2", int'(done), 1);
    @(negedge clk);
    chk("b2b_idle2", int'(busy), 0);
    m_bank[5] = 8'h11; m_bank[6] = 8'h22;
    chk("b2b_r5", int'(u_rb.r_regs[5]), 8'h11);
    chk("b2b_r6", int'(u_rb.r_regs[6]), 8'h22);
    // A request pulsed while busy is dropped
    stb = 1'b1; op = 2'b01; dst = 3'd3; imm = 8'h33;
    @(negedge clk);
    dst = 3'd0; imm = 8'h77;
    @(negedge clk);
    stb = 1'b0;
    chk("drop_fin", int'(done), 1);
    @(negedge clk);
    chk("drop_idle", int'(busy), 0);
    @(negedge clk);
    chk("drop_still_idle", int'(busy), 0);
    m_bank[3] = 8'h33;
    chk("drop_r3", int'(u_rb.r_regs[3]), 8'h33);
    chk("drop_r0", int'(u_rb.r_regs[0]), int'(m_bank[0]));
    for (int n = 0; n < 60; n++)
      run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom));
    // Reset asserted during STEP of an INR aborts it without DONE
    stb = 1'b1; op = 2'b10; dst = 3'd1; src = 3'd0; imm = 8'h00;
    @(negedge clk);
    stb = 1'b0;
    chk("mid_inc", int'(inc), 1);
    nrst = 1'b0;
    #1;
    model_reset();
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_flag", int'(flag), 0);
    chk_bus("mid", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_done_hold", int'(done), 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("post_busy", int'(busy), 0);
    chk("post_done", int'(done), 0);
    run_op(2'b01, 3'd2, 3'd0, 8'h3C);
    run_op(2'b11, 3'd2, 3'd0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
